// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, N+1 cycles from accept to done.
// Optional signed mode is enabled by defining SIGNED_DIV_EN (default build is unsigned only).
`timescale 1ns/1ps
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         sgn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: start is taken on any rising edge where the FSM is in IDLE or DONE;
  // done pulses for exactly one cycle and results hold until the next accepted start.

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_d;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_remd;
  logic           r_dbz;

  logic           w_accept;
  logic           w_div_zero;
  logic [N:0]     w_shift;
  logic [N:0]     w_trial;
  logic [N:0]     w_rem_next;
  logic [N-1:0]   w_q_next;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic [N-1:0]   w_q_final;
  logic [N-1:0]   w_r_final;

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_div_zero = (divisor == '0);

  // {R,Q} shifted left by one, then a trial subtract of the zero-extended divisor.
  assign w_shift    = {r_rem[N-1:0], r_q[N-1]};
  assign w_trial    = w_shift - {1'b0, r_d};
  assign w_rem_next = w_trial[N] ? w_shift : w_trial;
  assign w_q_next   = {r_q[N-2:0], ~w_trial[N]};

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg   = sgn & dividend[N-1];
  assign w_b_neg   = sgn & divisor[N-1];
  assign w_a_mag   = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag   = w_b_neg ? (~divisor + 1'b1) : divisor;
  // Truncation toward zero: remainder follows the dividend sign.
  assign w_q_final = r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
  assign w_r_final = r_neg_r ? (~w_rem_next[N-1:0] + 1'b1) : w_rem_next[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_a_mag      = dividend;
  assign w_b_mag      = divisor;
  assign w_q_final    = w_q_next;
  assign w_r_final    = w_rem_next[N-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_dbz <= w_div_zero;
            if (w_div_zero) begin
              // No iteration needed: results are fixed by definition.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remd  <= dividend;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_rem   <= '0;
              r_q     <= w_a_mag;
              r_d     <= w_b_mag;
              r_cnt   <= CW'(N - 1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_final;
            r_remd  <= w_r_final;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=8): scoreboard of expected {div_by_zero, quotient, remainder}.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int N = 8;
`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [2*N:0] exp_q[$];

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .sgn(sgn), .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    int sa, sb;
    logic [N-1:0] q, r;
    if (b == '0) return {1'b1, {N{1'b1}}, a};
    q = a / b;
    r = a % b;
    if (s & SIGNED_BUILD) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = N'(sa / sb);
      r = N'(sa % sb);
    end
    return {1'b0, q, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a negedge with the DUT in IDLE or DONE; returns at the first cycle after accept.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    dividend = a;
    divisor  = b;
    sgn      = s;
    start    = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    sgn      = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 4 * N) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got %h required 0",
               {busy, done, quotient, remainder, div_by_zero, dbg_state});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [2*N:0] exp;
    issue(8'd100, 8'd7, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== N + 1 || bc !== N) begin
      miscompares++;
      $display("FAIL basic_latency: got lat=%0d busy=%0d required lat=%0d busy=%0d", lat, bc, N + 1, N);
    end
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || quotient !== 8'd14 || remainder !== 8'd2) begin
      miscompares++;
      $display("FAIL basic_result: got %h required %h (q=14 r=2)", {div_by_zero, quotient, remainder}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat, bc;
    logic [2*N:0] exp;
    issue(8'h05, 8'h00, 1'b0);
    wait_done(lat, bc);
    vectors++;
    if (lat !== 1 || bc !== 0) begin
      miscompares++;
      $display("FAIL dz_latency: got lat=%0d busy=%0d required lat=1 busy=0", lat, bc);
    end
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || exp !== {1'b1, 8'hFF, 8'h05}) begin
      miscompares++;
      $display("FAIL dz_result: got %h required %h", {div_by_zero, quotient, remainder}, exp);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, div_by_zero, quotient, remainder} !== {1'b0, 1'b1, 8'hFF, 8'h05}) begin
      miscompares++;
      $display("FAIL dz_hold: got %h required %h", {done, div_by_zero, quotient, remainder},
               {1'b0, 1'b1, 8'hFF, 8'h05});
    end
    issue(8'd100, 8'd7, 1'b0);
    vectors++;
    if ({busy, div_by_zero, quotient, remainder} !== {1'b1, 1'b0, 8'hFF, 8'h05}) begin
      miscompares++;
      $display("FAIL dz_retain_on_start: got %h required %h", {busy, div_by_zero, quotient, remainder},
               {1'b1, 1'b0, 8'hFF, 8'h05});
    end
    wait_done(lat, bc);
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp) begin
      miscompares++;
      $display("FAIL dz_followup: got %h required %h", {div_by_zero, quotient, remainder}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [2*N:0] exp;
    issue(8'd200, 8'd201, 1'b0);
    wait_done(lat, bc);
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || exp !== {1'b0, 8'd0, 8'd200}) begin
      miscompares++;
      $display("FAIL b2b_first: got %h required %h", {div_by_zero, quotient, remainder}, exp);
    end
    issue(8'd255, 8'd1, 1'b0);
    vectors++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_no_idle: got busy=%b state=%0d required busy=1 state=1", busy, dbg_state);
    end
    wait_done(lat, bc);
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || lat !== N + 1) begin
      miscompares++;
      $display("FAIL b2b_second: got %h lat=%0d required %h lat=%0d",
               {div_by_zero, quotient, remainder}, lat, exp, N + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_run();
    int lat, bc, extra;
    logic [2*N:0] exp;
    issue(8'd50, 8'd3, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      start    = (i == 2 || i == 5);
      dividend = 8'd99;
      divisor  = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(lat, bc);
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || quotient !== 8'd16 || remainder !== 8'd2) begin
      miscompares++;
      $display("FAIL run_ignore_start: got %h required %h", {div_by_zero, quotient, remainder}, exp);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL run_no_extra_op: got %0d extra cycles state=%0d required 0 and 0", extra, dbg_state);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, spurious;
    logic [2*N:0] exp;
    issue(8'd77, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero, dbg_state} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %h required 0",
               {busy, done, quotient, remainder, div_by_zero, dbg_state});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got %0d done pulses required 0", spurious);
    end
    issue(8'd9, 8'd3, 1'b0);
    wait_done(lat, bc);
    exp = exp_q.pop_front();
    vectors++;
    if ({div_by_zero, quotient, remainder} !== exp || quotient !== 8'd3 || remainder !== 8'd0) begin
      miscompares++;
      $display("FAIL midrun_recover: got %h required %h", {div_by_zero, quotient, remainder}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [N-1:0] a_tab[5] = '{8'hF9, 8'h07, 8'h80, 8'h85, 8'hFB};
    logic [N-1:0] b_tab[5] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'hFD};
    int lat, bc;
    logic [2*N:0] exp;
    for (int i = 0; i < 5; i++) begin
      issue(a_tab[i], b_tab[i], 1'b1);
      wait_done(lat, bc);
      exp = exp_q.pop_front();
      vectors++;
      if ({div_by_zero, quotient, remainder} !== exp) begin
        miscompares++;
        $display("FAIL signed_op%0d: %h/%h got %h required %h", i, a_tab[i], b_tab[i],
                 {div_by_zero, quotient, remainder}, exp);
      end
`ifdef SIGNED_DIV_EN
      if (i == 2) begin
        vectors++;
        if ({div_by_zero, quotient, remainder} !== {1'b0, 8'h80, 8'h00}) begin
          miscompares++;
          $display("FAIL signed_overflow: got %h required 08000", {div_by_zero, quotient, remainder});
        end
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2*N:0] exp;
    logic [N-1:0] a, b;
    logic s;
    for (int i = 0; i < 30; i++) begin
      a = N'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : N'($urandom_range(1, 255));
      s = 1'($urandom_range(0, 1));
      issue(a, b, s);
      wait_done(lat, bc);
      exp = exp_q.pop_front();
      vectors++;
      if ({div_by_zero, quotient, remainder} !== exp) begin
        miscompares++;
        $display("FAIL random%0d: %h/%h sgn=%b got %h required %h", i, a, b, s,
                 {div_by_zero, quotient, remainder}, exp);
      end
      if (b != 0 && !(s && SIGNED_BUILD)) begin
        vectors++;
        if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
          miscompares++;
          $display("FAIL random_identity%0d: %h/%h got q=%h r=%h", i, a, b, quotient, remainder);
        end
      end
      // Mix back-to-back starts with starts from IDLE.
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    test_signed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
